pipe_stage: RTL and testbench

//  Generic pipeline stage register with a valid/ready handshake; successor to the fixed per-stage

---
 rtl/pipe_stage_pkg.sv | 33 +++
 rtl/pipe_stage_if.sv | 13 +
 rtl/pipe_stage_entry.sv | 40 ++++
 rtl/pipe_stage.sv | 110 +++++++++++
 tb/tb_pipe_stage.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_stage_pkg.sv
// Shared widths and per-stage control-bit layouts; stages pack these structs into in_ctrl.
package pipe_stage_pkg;

  localparam int unsigned PIPE_DATA_W = 16;
  localparam int unsigned PIPE_CTRL_W = 16;
  localparam int unsigned PIPE_CNT_W  = 16;

  typedef struct packed {
    logic       regwrite;
    logic       mem_read;
    logic       mem_write;
    logic [3:0] alu_op;
    logic       alu_src;
    logic       halt;
    logic [6:0] rsvd;
  } id_ex_ctrl_t;

  typedef struct packed {
    logic        regwrite;
    logic        mem_read;
    logic        mem_write;
    logic        halt;
    logic [11:0] rsvd;
  } ex_mem_ctrl_t;

  typedef struct packed {
    logic        regwrite;
    logic        mem_to_reg;
    logic        halt;
    logic [12:0] rsvd;
  } mem_wb_ctrl_t;

endpackage

// File: rtl/pipe_stage_if.sv
// One valid/ready channel carrying a split data/control payload between pipeline stages.
interface pipe_stage_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CTRL_W = 16
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input ready);
  modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_stage_entry.sv
// Single payload slot: valid + control + data; control is zeroed whenever the slot goes empty.
module pipe_stage_entry #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned CTRL_W = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_load,
  input  logic              i_clr,
  input  logic              i_valid,
  input  logic [DATA_W-1:0] i_data,
  input  logic [CTRL_W-1:0] i_ctrl,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [CTRL_W-1:0] o_ctrl
);
  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [CTRL_W-1:0] r_ctrl;

  // Data is only written by a real beat so a bubble keeps the stale value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
      r_ctrl  <= '0;
    end else if (i_clr) begin
      r_valid <= 1'b0;
      r_ctrl  <= '0;
    end else if (i_load) begin
      r_valid <= i_valid;
      r_ctrl  <= i_valid ? i_ctrl : '0;
      if (i_valid) r_data <= i_data;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_ctrl  = r_ctrl;
endmodule

// File: rtl/pipe_stage.sv
// Pipeline stage register with valid/ready handshake, optional skid slot, flush and stall counter.
module pipe_stage
  import pipe_stage_pkg::*;
#(
  parameter int unsigned DATA_W  = PIPE_DATA_W,
  parameter int unsigned CTRL_W  = PIPE_CTRL_W,
  parameter bit          SKID_EN = 1'b1,
  parameter int unsigned CNT_W   = PIPE_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  pipe_stage_if.slave      in_if,
  pipe_stage_if.master     out_if,
  input  logic             flush,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [1:0]       occupancy
);
  logic              w_main_v;
  logic              w_skid_v;
  logic              w_in_ready;
  logic              w_push;
  logic              w_pop;
  logic              w_main_load;
  logic              w_main_in_v;
  logic [DATA_W-1:0] w_main_in_d;
  logic [CTRL_W-1:0] w_main_in_c;
  logic [DATA_W-1:0] w_main_d;
  logic [CTRL_W-1:0] w_main_c;
  logic [CNT_W-1:0]  r_stall_cnt;

  assign w_push      = in_if.valid & w_in_ready;
  assign w_pop       = w_main_v & out_if.ready;
  assign w_main_load = !w_main_v | w_pop;

  generate
    if (SKID_EN) begin : g_skid
      logic              w_skid_load;
      logic [DATA_W-1:0] w_skid_d;
      logic [CTRL_W-1:0] w_skid_c;

      // Skid catches a beat only when main is stuck, and drains into main before newer beats.
      assign w_skid_load = (w_main_v & !w_pop & w_push) | (w_pop & w_skid_v);

      pipe_stage_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_skid (
        .clk     (clk),
        .reset_n (reset_n),
        .i_load  (w_skid_load),
        .i_clr   (flush),
        .i_valid (w_push),
        .i_data  (in_if.data),
        .i_ctrl  (in_if.ctrl),
        .o_valid (w_skid_v),
        .o_data  (w_skid_d),
        .o_ctrl  (w_skid_c)
      );

      assign w_in_ready  = !w_skid_v;
      assign w_main_in_v = w_skid_v | w_push;
      assign w_main_in_d = w_skid_v ? w_skid_d : in_if.data;
      assign w_main_in_c = w_skid_v ? w_skid_c : in_if.ctrl;
    end else begin : g_single
      assign w_skid_v    = 1'b0;
      assign w_in_ready  = !w_main_v | out_if.ready;
      assign w_main_in_v = w_push;
      assign w_main_in_d = in_if.data;
      assign w_main_in_c = in_if.ctrl;
    end
  endgenerate

  pipe_stage_entry #(.DATA_W(DATA_W), .CTRL_W(CTRL_W)) u_main (
    .clk     (clk),
    .reset_n (reset_n),
    .i_load  (w_main_load),
    .i_clr   (flush),
    .i_valid (w_main_in_v),
    .i_data  (w_main_in_d),
    .i_ctrl  (w_main_in_c),
    .o_valid (w_main_v),
    .o_data  (w_main_d),
    .o_ctrl  (w_main_c)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_stall_cnt <= '0;
    end else if (cnt_clr) begin
      r_stall_cnt <= '0;
    end else if (w_main_v && !out_if.ready && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign in_if.ready  = w_in_ready;
  assign out_if.valid = w_main_v;
  assign out_if.data  = w_main_d;
  assign out_if.ctrl  = w_main_v ? w_main_c : '0;
  assign stall_cnt    = r_stall_cnt;
  assign occupancy    = {1'b0, w_main_v} + {1'b0, w_skid_v};

  a_out_hold: assert property (@(posedge clk) disable iff (!reset_n)
    (out_if.valid && !out_if.ready && !flush) |=>
      (out_if.valid && $stable(out_if.data) && $stable(out_if.ctrl)));

  a_in_hold: assert property (@(posedge clk) disable iff (!reset_n)
    (in_if.valid && !in_if.ready && !flush) |=>
      (in_if.valid && $stable(in_if.data) && $stable(in_if.ctrl)));

  a_occ_max: assert property (@(posedge clk) disable iff (!reset_n) occupancy <= 2'd2);
endmodule

// File: tb/tb_pipe_stage.sv
// Bench for pipe_stage: skid instance (CNT_W=4) and single-entry instance, scoreboarded per instance.
module tb_pipe_stage;
  import pipe_stage_pkg::*;

  typedef struct packed {
    logic [15:0] d;
    logic [15:0] c;
  } beat_t;

  typedef struct {
    bit          nd;
    logic        iv;
    logic [15:0] d;
    logic        ordy;
    logic        ev;
    logic        eir;
    logic [1:0]  eocc;
    logic [15:0] ecnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        s_flush, s_clr, n_flush, n_clr;
  logic [3:0]  s_cnt;
  logic [15:0] n_cnt;
  logic [1:0]  s_occ, n_occ;
  int          n_vec = 0;
  int          n_err = 0;
  beat_t       q_s[$];
  beat_t       q_n[$];
  vec_t        tbl[$];

  always #5 clk = ~clk;

  pipe_stage_if #(.DATA_W(16), .CTRL_W(16)) s_in ();
  pipe_stage_if #(.DATA_W(16), .CTRL_W(16)) s_out ();
  pipe_stage_if #(.DATA_W(16), .CTRL_W(16)) n_in ();
  pipe_stage_if #(.DATA_W(16), .CTRL_W(16)) n_out ();

  pipe_stage #(.DATA_W(16), .CTRL_W(16), .SKID_EN(1'b1), .CNT_W(4)) u_skid (
    .clk(clk), .reset_n(reset_n), .in_if(s_in), .out_if(s_out),
    .flush(s_flush), .cnt_clr(s_clr), .stall_cnt(s_cnt), .occupancy(s_occ));

  pipe_stage #(.DATA_W(16), .CTRL_W(16), .SKID_EN(1'b0), .CNT_W(16)) u_nosk (
    .clk(clk), .reset_n(reset_n), .in_if(n_in), .out_if(n_out),
    .flush(n_flush), .cnt_clr(n_clr), .stall_cnt(n_cnt), .occupancy(n_occ));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] mk_ctrl(input logic [15:0] d);
    id_ex_ctrl_t c;
    c = id_ex_ctrl_t'(~d);
    c.regwrite = 1'b1;
    return c;
  endfunction

  function automatic vec_t mkv(input bit nd, input logic iv, input logic [15:0] d, input logic ordy,
                               input logic ev, input logic eir, input logic [1:0] eocc,
                               input logic [15:0] ecnt);
    vec_t v;
    v.nd = nd; v.iv = iv; v.d = d; v.ordy = ordy;
    v.ev = ev; v.eir = eir; v.eocc = eocc; v.ecnt = ecnt;
    return v;
  endfunction

  // Drive one cycle of stimulus after the edge, then return at the following negedge.
  task automatic step(input bit nd, input logic iv, input logic [15:0] d, input logic ordy,
                      input logic fl = 1'b0, input logic clr = 1'b0);
    @(posedge clk);
    #1;
    s_in.valid = 1'b0; s_in.data = '0; s_in.ctrl = '0; s_out.ready = 1'b1; s_flush = 1'b0; s_clr = 1'b0;
    n_in.valid = 1'b0; n_in.data = '0; n_in.ctrl = '0; n_out.ready = 1'b1; n_flush = 1'b0; n_clr = 1'b0;
    if (nd) begin
      n_in.valid = iv; n_in.data = d; n_in.ctrl = mk_ctrl(d); n_out.ready = ordy;
      n_flush = fl; n_clr = clr;
    end else begin
      s_in.valid = iv; s_in.data = d; s_in.ctrl = mk_ctrl(d); s_out.ready = ordy;
      s_flush = fl; s_clr = clr;
    end
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    beat_t b;
    if (!reset_n) begin
      q_s.delete();
      q_n.delete();
    end else begin
      if (s_out.valid && s_out.ready) begin
        if (q_s.size() == 0) check("s_unexpected_beat", {s_out.data, s_out.ctrl}, 32'hFFFF_FFFF);
        else begin
          b = q_s.pop_front();
          check("s_out_beat", {s_out.data, s_out.ctrl}, b);
        end
      end
      if (s_flush) q_s.delete();
      else if (s_in.valid && s_in.ready) q_s.push_back({s_in.data, s_in.ctrl});

      if (n_out.valid && n_out.ready) begin
        if (q_n.size() == 0) check("n_unexpected_beat", {n_out.data, n_out.ctrl}, 32'hFFFF_FFFF);
        else begin
          b = q_n.pop_front();
          check("n_out_beat", {n_out.data, n_out.ctrl}, b);
        end
      end
      if (n_flush) q_n.delete();
      else if (n_in.valid && n_in.ready) q_n.push_back({n_in.data, n_in.ctrl});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0;
    s_in.valid = 1'b0; s_in.data = '0; s_in.ctrl = '0; s_out.ready = 1'b1; s_flush = 1'b0; s_clr = 1'b0;
    n_in.valid = 1'b0; n_in.data = '0; n_in.ctrl = '0; n_out.ready = 1'b1; n_flush = 1'b0; n_clr = 1'b0;

    #3;
    check("rst_s_valid", 32'(s_out.valid), 32'd0);
    check("rst_s_ctrl", 32'(s_out.ctrl), 32'd0);
    check("rst_s_cnt", 32'(s_cnt), 32'd0);
    check("rst_n_occ", 32'(n_occ), 32'd0);
    #9 reset_n = 1'b1;
    #1;
    check("rst_s_in_ready", 32'(s_in.ready), 32'd1);
    check("rst_n_in_ready", 32'(n_in.ready), 32'd1);

    // Backpressure through the skid slot: A main, B skid, C held upstream.
    tbl.push_back(mkv(0, 1, 16'h00A1, 0, 0, 1, 2'd0, 16'd0));
    tbl.push_back(mkv(0, 1, 16'h00B2, 0, 1, 1, 2'd1, 16'd0));
    tbl.push_back(mkv(0, 1, 16'h00C3, 0, 1, 0, 2'd2, 16'd1));
    tbl.push_back(mkv(0, 1, 16'h00C3, 0, 1, 0, 2'd2, 16'd2));
    tbl.push_back(mkv(0, 1, 16'h00C3, 1, 1, 0, 2'd2, 16'd3));
    tbl.push_back(mkv(0, 1, 16'h00C3, 1, 1, 1, 2'd1, 16'd3));
    tbl.push_back(mkv(0, 0, 16'h0000, 1, 1, 1, 2'd1, 16'd3));
    tbl.push_back(mkv(0, 0, 16'h0000, 1, 0, 1, 2'd0, 16'd3));
    // Single-entry: ready drops combinationally, then pop+push in one cycle.
    tbl.push_back(mkv(1, 1, 16'h0111, 0, 0, 1, 2'd0, 16'd0));
    tbl.push_back(mkv(1, 1, 16'h0222, 0, 1, 0, 2'd1, 16'd0));
    tbl.push_back(mkv(1, 1, 16'h0222, 1, 1, 1, 2'd1, 16'd1));
    tbl.push_back(mkv(1, 1, 16'h0333, 1, 1, 1, 2'd1, 16'd1));
    tbl.push_back(mkv(1, 0, 16'h0000, 1, 1, 1, 2'd1, 16'd1));
    tbl.push_back(mkv(1, 0, 16'h0000, 0, 0, 1, 2'd0, 16'd1));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].nd, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      check($sformatf("v%0d_out_valid", i), 32'(tbl[i].nd ? n_out.valid : s_out.valid), 32'(tbl[i].ev));
      check($sformatf("v%0d_in_ready", i), 32'(tbl[i].nd ? n_in.ready : s_in.ready), 32'(tbl[i].eir));
      check($sformatf("v%0d_occ", i), 32'(tbl[i].nd ? n_occ : s_occ), 32'(tbl[i].eocc));
      check($sformatf("v%0d_cnt", i), tbl[i].nd ? 32'(n_cnt) : 32'(s_cnt), 32'(tbl[i].ecnt));
      if (!tbl[i].ev)
        check($sformatf("v%0d_bubble_ctrl", i), 32'(tbl[i].nd ? n_out.ctrl : s_out.ctrl), 32'd0);
    end

    // Streaming with out_ready held high on both instances.
    for (int u = 0; u < 2; u++) begin
      for (int i = 1; i <= 8; i++) begin
        step(u == 1, 1'b1, 16'(i), 1'b1);
        check("stream_in_ready", 32'(u == 1 ? n_in.ready : s_in.ready), 32'd1);
        check("stream_occ", 32'(u == 1 ? n_occ : s_occ), (i == 1) ? 32'd0 : 32'd1);
        if (i > 1) check("stream_latency", 32'(u == 1 ? n_out.data : s_out.data), 32'(i - 1));
      end
      step(u == 1, 1'b0, 16'h0, 1'b1);
      check("stream_last", 32'(u == 1 ? n_out.data : s_out.data), 32'd8);
      step(u == 1, 1'b0, 16'h0, 1'b1);
      check("stream_drained", 32'(u == 1 ? n_out.valid : s_out.valid), 32'd0);
    end

    // Flush with both slots full, then flush with a beat accepted in the flush cycle.
    step(0, 1, 16'h0F01, 0);
    step(0, 1, 16'h0F02, 0);
    step(0, 1, 16'h0F03, 0, 1'b1);
    check("flush_pre_occ", 32'(s_occ), 32'd2);
    step(0, 0, 16'h0, 1);
    check("flush_valid", 32'(s_out.valid), 32'd0);
    check("flush_ctrl", 32'(s_out.ctrl), 32'd0);
    check("flush_occ", 32'(s_occ), 32'd0);
    check("flush_in_ready", 32'(s_in.ready), 32'd1);
    step(0, 1, 16'h0F04, 0);
    step(0, 1, 16'h0F05, 1, 1'b1);
    check("flush_push_ready", 32'(s_in.ready), 32'd1);
    step(0, 0, 16'h0, 1);
    check("flush2_valid", 32'(s_out.valid), 32'd0);
    check("flush2_occ", 32'(s_occ), 32'd0);
    step(0, 0, 16'h0, 1);
    step(0, 0, 16'h0, 1);

    // Stall counter saturation at 4 bits and clear priority.
    step(0, 1, 16'h0D01, 0, 1'b0, 1'b1);
    for (int k = 0; k < 20; k++) step(0, 0, 16'h0, 0);
    check("sat_cnt", 32'(s_cnt), 32'd15);
    step(0, 0, 16'h0, 0);
    check("sat_hold", 32'(s_cnt), 32'd15);
    step(0, 0, 16'h0, 0, 1'b0, 1'b1);
    step(0, 0, 16'h0, 1);
    check("sat_clr", 32'(s_cnt), 32'd0);
    step(0, 0, 16'h0, 1);
    check("sat_drained", 32'(s_out.valid), 32'd0);

    // Asynchronous reset with two beats held.
    step(0, 1, 16'h0E01, 0);
    step(0, 1, 16'h0E02, 0);
    step(0, 0, 16'h0, 0);
    check("mid_pre_occ", 32'(s_occ), 32'd2);
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(s_out.valid), 32'd0);
    check("mid_rst_ctrl", 32'(s_out.ctrl), 32'd0);
    check("mid_rst_cnt", 32'(s_cnt), 32'd0);
    check("mid_rst_occ", 32'(s_occ), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #2 reset_n = 1'b1;
    #1;
    check("mid_rel_in_ready", 32'(s_in.ready), 32'd1);
    step(0, 0, 16'h0, 1);
    check("mid_rel_valid", 32'(s_out.valid), 32'd0);

    check("s_queue_empty", 32'(q_s.size()), 32'd0);
    check("n_queue_empty", 32'(q_n.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
